startup_sequencer: RTL and testbench

//  Parametrised power-up sequencer for the Mojo top level. Qualifies AVR cclk (stable-high filter), then

---
 rtl/startup_sequencer_pkg.sv | 13 +
 rtl/startup_sequencer_sync_2ff.sv | 22 ++
 rtl/startup_sequencer.sv | 156 +++++++++++++++
 tb/tb_startup_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/startup_sequencer_pkg.sv
// Shared definitions for the power-up sequencer.
// State encodings also feed the top-level debug mux.
package startup_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/startup_sequencer_sync_2ff.sv
// Double-flop synchroniser for a single asynchronous pin.
// Resets to 0, so a pin reads low until two clean edges pass.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/startup_sequencer.sv
// Power-up sequencer: qualifies cclk, releases reset domains
// in staggered order, then runs a saturating cycle counter.
module startup_sequencer
    import startup_sequencer_pkg::*;
#(
    parameter int CCLK_STABLE = 512,
    parameter int N_CH        = 4,
    parameter int STAGGER     = 8,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 0,
    parameter int STICKY      = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cclk,
    input  logic             soft_rst,
    output logic [N_CH-1:0]  chan_rst,
    output logic             ready,
    output logic [CNT_W-1:0] cycle,
    output logic             timeout,
    output logic [1:0]       state
);

    localparam int SW = $clog2(CCLK_STABLE + 1);
    localparam int GW = $clog2(STAGGER + 1);
    localparam int IW = $clog2(N_CH + 1);

    localparam logic [SW-1:0]    STAB_END = SW'(CCLK_STABLE - 1);
    localparam logic [GW-1:0]    STAG_END = GW'(STAGGER - 1);
    localparam logic [IW-1:0]    IDX_END  = IW'(N_CH);
    localparam logic [CNT_W-1:0] CYC_MAX  = '1;
    localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);
    localparam bit               TO_EN    = (TIMEOUT != 0);
    localparam bit               DROP_RUN = (STICKY == 0);

    logic cclk_s;

    state_t            state_q, state_nx;
    logic [SW-1:0]     stab_q, stab_nx;
    logic [GW-1:0]     stag_q, stag_nx;
    logic [IW-1:0]     idx_q, idx_nx;
    logic [N_CH-1:0]   chan_q, chan_nx;
    logic              ready_q, ready_nx;
    logic [CNT_W-1:0]  cyc_q, cyc_nx;
    logic              to_q, to_nx;

    sync_2ff u_cclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (cclk),
        .q     (cclk_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            stab_q  <= '0;
            stag_q  <= '0;
            idx_q   <= '0;
            chan_q  <= '1;
            ready_q <= 1'b0;
            cyc_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_nx;
            stab_q  <= stab_nx;
            stag_q  <= stag_nx;
            idx_q   <= idx_nx;
            chan_q  <= chan_nx;
            ready_q <= ready_nx;
            cyc_q   <= cyc_nx;
            to_q    <= to_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        stab_nx  = stab_q;
        stag_nx  = stag_q;
        idx_nx   = idx_q;
        chan_nx  = chan_q;
        ready_nx = ready_q;
        cyc_nx   = cyc_q;
        to_nx    = to_q;
        if (soft_rst) begin
            state_nx = ST_WAIT;
            stab_nx  = '0;
            stag_nx  = '0;
            idx_nx   = '0;
            chan_nx  = '1;
            ready_nx = 1'b0;
            cyc_nx   = '0;
            to_nx    = 1'b0;
        end else begin
            unique case (state_q)
                ST_WAIT: begin
                    if (!cclk_s) begin
                        stab_nx = '0;
                    end else if (stab_q == STAB_END) begin
                        state_nx = ST_RELEASE;
                        chan_nx  = chan_q << 1;
                        idx_nx   = IW'(1);
                        stag_nx  = '0;
                        stab_nx  = '0;
                    end else begin
                        stab_nx = stab_q + SW'(1);
                    end
                end
                ST_RELEASE: begin
                    if (!cclk_s) begin
                        state_nx = ST_WAIT;
                        chan_nx  = '1;
                        stab_nx  = '0;
                        stag_nx  = '0;
                        idx_nx   = '0;
                    end else if (idx_q == IDX_END) begin
                        state_nx = ST_RUN;
                        ready_nx = 1'b1;
                        cyc_nx   = '0;
                    end else if (stag_q == STAG_END) begin
                        // shift a 0 in: bit 0 goes first, bits never return to 1
                        chan_nx = chan_q << 1;
                        idx_nx  = idx_q + IW'(1);
                        stag_nx = '0;
                    end else begin
                        stag_nx = stag_q + GW'(1);
                    end
                end
                ST_RUN: begin
                    if (!cclk_s && DROP_RUN) begin
                        state_nx = ST_WAIT;
                        chan_nx  = '1;
                        ready_nx = 1'b0;
                        cyc_nx   = '0;
                        stab_nx  = '0;
                        stag_nx  = '0;
                        idx_nx   = '0;
                    end else if (cyc_q != CYC_MAX) begin
                        cyc_nx = cyc_q + CNT_W'(1);
                        if (TO_EN && cyc_nx == TO_VAL) begin
                            to_nx = 1'b1;
                        end
                    end
                end
                default: state_nx = ST_WAIT;
            endcase
        end
    end

    assign chan_rst = chan_q;
    assign ready    = ready_q;
    assign cycle    = cyc_q;
    assign timeout  = to_q;
    assign state    = state_q;

endmodule

// File: tb/tb_startup_sequencer.sv
// Directed bench: main instance (sticky) plus a narrow-counter,
// non-sticky instance driven by the same pins.
module tb_startup_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    logic cclk;
    logic soft_rst;

    logic [2:0]  a_chan;
    logic        a_ready;
    logic [31:0] a_cycle;
    logic        a_to;
    logic [1:0]  a_state;

    logic [2:0]  b_chan;
    logic        b_ready;
    logic [3:0]  b_cycle;
    logic        b_to;
    logic [1:0]  b_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    startup_sequencer #(
        .CCLK_STABLE (16),
        .N_CH        (3),
        .STAGGER     (4),
        .CNT_W       (32),
        .TIMEOUT     (100),
        .STICKY      (1)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .cclk     (cclk),
        .soft_rst (soft_rst),
        .chan_rst (a_chan),
        .ready    (a_ready),
        .cycle    (a_cycle),
        .timeout  (a_to),
        .state    (a_state)
    );

    startup_sequencer #(
        .CCLK_STABLE (16),
        .N_CH        (3),
        .STAGGER     (4),
        .CNT_W       (4),
        .TIMEOUT     (10),
        .STICKY      (0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .cclk     (cclk),
        .soft_rst (soft_rst),
        .chan_rst (b_chan),
        .ready    (b_ready),
        .cycle    (b_cycle),
        .timeout  (b_to),
        .state    (b_state)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        cclk     = 1'b0;
        soft_rst = 1'b0;
        step(3);
        chk("rst_chan", 64'(a_chan), 64'h7);
        chk("rst_ready", 64'(a_ready), 64'h0);
        chk("rst_cycle", 64'(a_cycle), 64'h0);
        chk("rst_to", 64'(a_to), 64'h0);
        chk("rst_state", 64'(a_state), 64'h0);
        rst_n = 1'b1;
        step(2);

        // t1: clean power-up sequence
        cclk = 1'b1;
        step(17);
        chk("t1_chan@17", 64'(a_chan), 64'h7);
        step(1);
        chk("t1_chan@18", 64'(a_chan), 64'h6);
        chk("t1_state@18", 64'(a_state), 64'h1);
        step(3);
        chk("t1_chan@21", 64'(a_chan), 64'h6);
        step(1);
        chk("t1_chan@22", 64'(a_chan), 64'h4);
        step(4);
        chk("t1_chan@26", 64'(a_chan), 64'h0);
        chk("t1_ready@26", 64'(a_ready), 64'h0);
        step(1);
        chk("t1_ready@27", 64'(a_ready), 64'h1);
        chk("t1_cycle@27", 64'(a_cycle), 64'h0);
        chk("t1_state@27", 64'(a_state), 64'h2);
        chk("t1_b_ready", 64'(b_ready), 64'h1);

        // t4: watchdog and saturation
        step(99);
        chk("t4_cycle99", 64'(a_cycle), 64'd99);
        chk("t4_to99", 64'(a_to), 64'h0);
        step(1);
        chk("t4_cycle100", 64'(a_cycle), 64'd100);
        chk("t4_to100", 64'(a_to), 64'h1);
        chk("t4_b_sat", 64'(b_cycle), 64'd15);
        chk("t4_b_to", 64'(b_to), 64'h1);
        step(5);
        chk("t4_to_hold", 64'(a_to), 64'h1);
        chk("t4_cycle105", 64'(a_cycle), 64'd105);

        // t5: cclk drop in RUN
        cclk = 1'b0;
        step(2);
        chk("t5_b_state_sync", 64'(b_state), 64'h2);
        step(1);
        chk("t5_b_chan", 64'(b_chan), 64'h7);
        chk("t5_b_ready", 64'(b_ready), 64'h0);
        chk("t5_b_cycle", 64'(b_cycle), 64'h0);
        chk("t5_b_to", 64'(b_to), 64'h1);
        chk("t5_b_state", 64'(b_state), 64'h0);
        chk("t5_a_state", 64'(a_state), 64'h2);
        chk("t5_a_chan", 64'(a_chan), 64'h0);
        chk("t5_a_cycle", 64'(a_cycle), 64'd108);

        // t6a: soft reset pulse in RUN
        soft_rst = 1'b1;
        step(1);
        soft_rst = 1'b0;
        chk("t6_chan", 64'(a_chan), 64'h7);
        chk("t6_ready", 64'(a_ready), 64'h0);
        chk("t6_cycle", 64'(a_cycle), 64'h0);
        chk("t6_to", 64'(a_to), 64'h0);
        chk("t6_state", 64'(a_state), 64'h0);
        chk("t6_b_to", 64'(b_to), 64'h0);

        // t2: one-cycle cclk glitch restarts qualification
        cclk = 1'b1;
        step(10);
        cclk = 1'b0;
        step(1);
        cclk = 1'b1;
        step(17);
        chk("t2_chan@17", 64'(a_chan), 64'h7);
        chk("t2_b_chan@17", 64'(b_chan), 64'h7);
        step(1);
        chk("t2_chan@18", 64'(a_chan), 64'h6);
        chk("t2_b_chan@18", 64'(b_chan), 64'h6);

        // t3: cclk drop during RELEASE
        step(4);
        chk("t3_chan@22", 64'(a_chan), 64'h4);
        cclk = 1'b0;
        step(2);
        chk("t3_chan@24", 64'(a_chan), 64'h4);
        chk("t3_state@24", 64'(a_state), 64'h1);
        step(1);
        chk("t3_chan@25", 64'(a_chan), 64'h7);
        chk("t3_ready@25", 64'(a_ready), 64'h0);
        chk("t3_state@25", 64'(a_state), 64'h0);
        cclk = 1'b1;
        step(17);
        chk("t3r_chan@17", 64'(a_chan), 64'h7);
        step(1);
        chk("t3r_chan@18", 64'(a_chan), 64'h6);
        step(9);
        chk("t3r_ready", 64'(a_ready), 64'h1);
        chk("t3r_chan", 64'(a_chan), 64'h0);
        chk("t3r_state", 64'(a_state), 64'h2);

        // t6b: held soft reset, then async reset mid-RELEASE
        soft_rst = 1'b1;
        step(3);
        chk("t6h_state", 64'(a_state), 64'h0);
        chk("t6h_chan", 64'(a_chan), 64'h7);
        soft_rst = 1'b0;
        step(15);
        chk("t6h_chan@15", 64'(a_chan), 64'h7);
        step(1);
        chk("t6h_chan@16", 64'(a_chan), 64'h6);
        step(2);
        rst_n = 1'b0;
        #2;
        chk("t6r_chan_async", 64'(a_chan), 64'h7);
        chk("t6r_state_async", 64'(a_state), 64'h0);
        chk("t6r_ready_async", 64'(a_ready), 64'h0);
        step(2);
        rst_n = 1'b1;
        step(17);
        chk("t6r_chan@17", 64'(a_chan), 64'h7);
        step(1);
        chk("t6r_chan@18", 64'(a_chan), 64'h6);
        step(9);
        chk("t6r_ready", 64'(a_ready), 64'h1);
        chk("t6r_cycle", 64'(a_cycle), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
